// File: rtl/delayed_lif_neuron.sv
// Leaky integrate-and-fire neuron with per-synapse tick-driven delay lines.
// Optional fired-spike counter is built only when NEURON_SPIKE_COUNT_EN is defined.
module delayed_lif_neuron #(
  parameter int M  = 4,
  parameter int W  = 8,
  parameter int DW = 3,
  parameter int VW = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 delay_tick,
  input  logic [M-1:0]         input_spikes,
  input  logic [M*W-1:0]       weights,
  input  logic signed [VW-1:0] threshold,
  input  logic [VW-1:0]        decay,
  input  logic [7:0]           refractory_period,
  input  logic [M*DW-1:0]      delay_values,
  input  logic [M-1:0]         delay_en,
  output logic                 spike_out,
  output logic signed [VW-1:0] membrane,
  output logic                 refractory,
  output logic [15:0]          spike_count
);

  localparam int D = (1 << DW) - 1;
  localparam logic signed [VW-1:0] V_MAX = {1'b0, {(VW-1){1'b1}}};
  localparam logic signed [VW-1:0] V_MIN = {1'b1, {(VW-1){1'b0}}};

  typedef enum logic {INTEG, REFRACT} state_t;

  state_t                state_q;
  logic signed [VW-1:0]  v_q;
  logic [7:0]            cnt_q;
  logic                  spike_q;
  logic                  tick_q;
  logic [M-1:0]          pend_q, pend_d;
  logic [D-1:0]          sr_q [M];
  logic [D-1:0]          sr_d [M];

  logic [DW-1:0]         dsel [M];
  logic [M-1:0]          evt;
  logic signed [VW-1:0]  syn_sum;
  logic signed [VW+1:0]  v_ext, dec_ext, diff;
  logic signed [VW-1:0]  leak;
  logic signed [VW:0]    sum_ext;
  logic signed [VW-1:0]  v_d;
  logic                  fire;

  // Pending bits hold spikes arriving between ticks; a tick folds them into the line.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < M; i++) begin
      sr_d[i] = sr_q[i];
      if (delay_tick) begin
        sr_d[i]   = (sr_q[i] << 1) | D'(pend_q[i] | input_spikes[i]);
        pend_d[i] = 1'b0;
      end else if (input_spikes[i]) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    evt = '0;
    for (int i = 0; i < M; i++) begin
      dsel[i] = delay_values[i*DW +: DW];
      if (delay_en[i] && (dsel[i] != '0))
        evt[i] = tick_q & sr_q[i][dsel[i] - DW'(1)];
      else
        evt[i] = input_spikes[i];
    end
  end

  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < M; i++) begin
      if (evt[i])
        syn_sum = syn_sum + {{(VW-W){weights[i*W+W-1]}}, weights[i*W +: W]};
    end
  end

  // Leak pulls v toward zero without crossing it; two guard bits keep the difference exact.
  always_comb begin
    v_ext   = {{2{v_q[VW-1]}}, v_q};
    dec_ext = {2'b00, decay};
    diff    = '0;
    leak    = '0;
    if (v_q > 0) begin
      diff = v_ext - dec_ext;
      leak = (diff < 0) ? '0 : diff[VW-1:0];
    end else if (v_q < 0) begin
      diff = v_ext + dec_ext;
      leak = (diff > 0) ? '0 : diff[VW-1:0];
    end
  end

  always_comb begin
    sum_ext = {leak[VW-1], leak} + {syn_sum[VW-1], syn_sum};
    if (sum_ext[VW] != sum_ext[VW-1])
      v_d = sum_ext[VW] ? V_MIN : V_MAX;
    else
      v_d = sum_ext[VW-1:0];
    fire = (state_q == INTEG) && (v_d >= threshold);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INTEG;
      v_q     <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
      tick_q  <= 1'b0;
      pend_q  <= '0;
      for (int i = 0; i < M; i++) sr_q[i] <= '0;
    end else if (enable) begin
      tick_q  <= delay_tick;
      pend_q  <= pend_d;
      for (int i = 0; i < M; i++) sr_q[i] <= sr_d[i];
      spike_q <= 1'b0;
      case (state_q)
        INTEG: begin
          if (fire) begin
            v_q     <= '0;
            spike_q <= 1'b1;
            cnt_q   <= refractory_period;
            state_q <= (refractory_period != 8'd0) ? REFRACT : INTEG;
          end else begin
            v_q <= v_d;
          end
        end
        REFRACT: begin
          v_q   <= '0;
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_q <= INTEG;
        end
        default: state_q <= INTEG;
      endcase
    end else begin
      spike_q <= 1'b0;
    end
  end

  assign spike_out  = spike_q;
  assign membrane   = v_q;
  assign refractory = (state_q == REFRACT);

`ifdef NEURON_SPIKE_COUNT_EN
  logic [15:0] spk_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      spk_cnt_q <= '0;
    else if (enable && fire && (spk_cnt_q != 16'hFFFF))
      spk_cnt_q <= spk_cnt_q + 16'd1;
  end

  assign spike_count = spk_cnt_q;
`else
  assign spike_count = '0;
`endif

endmodule
